// File: rtl/div_pkg.sv
// Shared encodings for the iterative RV32M divide/remainder unit.
// Holds the op codes, the iteration count and the FSM state encoding.
package div_pkg;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        FIXUP = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, then
// trial-subtract the divisor magnitude from the 33-bit partial remainder.
module div_step (
    input  logic [32:0] rem_i,
    input  logic        bit_i,
    input  logic [31:0] dsr_i,
    output logic [32:0] rem_o,
    output logic        q_o
);

    logic [32:0] shifted;
    logic        step_unused;

    // The stored remainder is always below the divisor, so bit 32 is zero.
    assign step_unused = rem_i[32];
    assign shifted     = {rem_i[31:0], bit_i};
    assign q_o         = (shifted >= {1'b0, dsr_i});
    assign rem_o       = q_o ? (shifted - {1'b0, dsr_i}) : shifted;

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to skip iteration for divide-by-zero/overflow.
module div_iter_unit
    import div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic [XLEN-1:0] dsav_q, dsav_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            is_rem_q, is_rem_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic [XLEN:0]   step_rem;
    logic            step_q;
    logic            sgn, a_neg, b_neg, is_div0, is_ovf;
    logic [XLEN-1:0] q_fix, r_fix;

    div_step u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[XLEN-1]),
        .dsr_i (dsr_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    assign sgn     = ~op[0];
    assign a_neg   = sgn & dividend[XLEN-1];
    assign b_neg   = sgn & divisor[XLEN-1];
    assign is_div0 = (divisor == '0);
    assign is_ovf  = sgn && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                         && (divisor == '1);

    always_comb begin
        q_fix = qneg_q ? (~dvd_q + 1'b1) : dvd_q;
        r_fix = rneg_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
        if (div0_q) begin
            q_fix = '1;
            r_fix = dsav_q;
        end else if (ovf_q) begin
            q_fix = {1'b1, {(XLEN-1){1'b0}}};
            r_fix = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        dsav_d   = dsav_q;
        result_d = result_q;
        is_rem_d = is_rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    is_rem_d = op[1];
                    dsav_d   = dividend;
                    dvd_d    = a_neg ? (~dividend + 1'b1) : dividend;
                    dsr_d    = b_neg ? (~divisor + 1'b1) : divisor;
                    qneg_d   = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    div0_d   = is_div0;
                    ovf_d    = is_ovf;
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (is_div0 || is_ovf) state_d = FIXUP;
`endif
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[XLEN-2:0], step_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_d = FIXUP;
            end
            FIXUP: begin
                result_d = is_rem_q ? r_fix : q_fix;
                done_d   = 1'b1;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            dsav_q   <= '0;
            result_q <= '0;
            is_rem_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            dsav_q   <= dsav_d;
            result_q <= result_d;
            is_rem_q <= is_rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule
